bias_add_stage: RTL and testbench

//  Per-channel bias adder for conv/squeeze layer outputs. Holds a writable

---
 rtl/bias_add_stage.sv | 139 +++++++++++++
 tb/tb_bias_add_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_stage.sv
// Per-channel bias adder: sign-magnitude bias bank, 2-stage elastic pipeline, saturating output.
// Optional BIAS_RELU_EN clamps negative results to zero after saturation.
module bias_add_stage #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bias_we_i,
  input  logic [CH_W-1:0]   bias_waddr_i,
  input  logic [BIAS_W-1:0] bias_wdata_i,
  input  logic              ch_clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ACC_W-1:0]  in_acc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic              out_last_o,
  output logic              sat_flag_o
);

  localparam logic [CH_W-1:0] ChLast = CH_W'(NUM_CH - 1);
  localparam logic signed [ACC_W:0] SatMax =
    {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SatMin =
    {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic [BIAS_W-1:0]       bias_q [NUM_CH];
  logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic                    s1_valid_q;
  logic [ACC_W-1:0]        s1_acc_q;
  logic signed [ACC_W:0]   s1_bias_q;
  logic [CH_W-1:0]         s1_ch_q;
  logic                    out_valid_q, out_last_q, sat_q;
  logic [DATA_W-1:0]       out_data_q;
  logic [CH_W-1:0]         out_ch_q;

  logic                    accept, s1_load, s2_load;
  logic [BIAS_W-1:0]       bias_rd;
  logic signed [ACC_W:0]   bias_dec;
  logic signed [ACC_W:0]   sum;
  logic [DATA_W-1:0]       res;
  logic                    res_sat;

  assign s2_load    = !out_valid_q || out_ready_i;
  assign s1_load    = !s1_valid_q || s2_load;
  assign in_ready_o = s1_load;
  assign accept     = in_valid_i && s1_load;

  // Out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) bias_q[i] <= '0;
    end else if (bias_we_i) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bias_waddr_i == CH_W'(i)) bias_q[i] <= bias_wdata_i;
      end
    end
  end

  always_comb begin
    bias_rd  = bias_q[ch_cnt_q];
    bias_dec = (ACC_W + 1)'(bias_rd[BIAS_W-2:0]);
    if (bias_rd[BIAS_W-1]) bias_dec = -bias_dec;
  end

  always_comb begin
    ch_cnt_d = ch_cnt_q;
    if (accept) ch_cnt_d = (ch_cnt_q == ChLast) ? '0 : ch_cnt_q + 1'b1;
    if (ch_clr_i) ch_cnt_d = '0;
  end

  always_comb begin
    sum     = {s1_acc_q[ACC_W-1], s1_acc_q} + s1_bias_q;
    res     = sum[DATA_W-1:0];
    res_sat = 1'b0;
    if (sum > SatMax) begin
      res     = {1'b0, {(DATA_W - 1){1'b1}}};
      res_sat = 1'b1;
    end else if (sum < SatMin) begin
      res     = {1'b1, {(DATA_W - 1){1'b0}}};
      res_sat = 1'b1;
    end
`ifdef BIAS_RELU_EN
    // ReLU leaves sat_flag untouched so a clamped negative still reports saturation.
    if (res[DATA_W-1]) res = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_acc_q   <= '0;
      s1_bias_q  <= '0;
      s1_ch_q    <= '0;
    end else begin
      ch_cnt_q <= ch_cnt_d;
      if (s1_load) begin
        s1_valid_q <= in_valid_i;
        if (in_valid_i) begin
          s1_acc_q  <= in_acc_i;
          s1_bias_q <= bias_dec;
          s1_ch_q   <= ch_cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= res;
        out_ch_q   <= s1_ch_q;
        out_last_q <= (s1_ch_q == ChLast);
        sat_q      <= res_sat;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_last_o  = out_last_q;
  assign sat_flag_o  = sat_q;

endmodule

// File: tb/tb_bias_add_stage.sv
// Bench for bias_add_stage: arithmetic reference model with scoreboard, directed literal cases,
// then randomized traffic with backpressure, bias writes, counter clears and a mid-stream reset.
module tb_bias_add_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bias_we = 1'b0;
  logic [3:0]  bias_waddr = '0;
  logic [15:0] bias_wdata = '0;
  logic        ch_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_acc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_ch;
  logic        out_last;
  logic        sat_flag;

  int total = 0;
  int bad = 0;

  bias_add_stage #(.NUM_CH(16), .ACC_W(24), .BIAS_W(16), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bias_we_i    (bias_we),
    .bias_waddr_i (bias_waddr),
    .bias_wdata_i (bias_wdata),
    .ch_clr_i     (ch_clr),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_acc_i     (in_acc),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_ch_o     (out_ch),
    .out_last_o   (out_last),
    .sat_flag_o   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  typedef struct {
    int data;
    int ch;
    int last;
    int sat;
  } exp_t;

  // Reference: plain integer arithmetic on the decoded bias.
  function automatic exp_t model(input logic [23:0] acc, input logic [15:0] b, input int ch);
    exp_t e;
    int   mag, bv, sum;
    mag = int'(b[14:0]);
    bv  = b[15] ? -mag : mag;
    sum = int'($signed(acc)) + bv;
    e.sat = 0;
    if (sum > 32767) begin
      sum = 32767;
      e.sat = 1;
    end else if (sum < -32768) begin
      sum = -32768;
      e.sat = 1;
    end
`ifdef BIAS_RELU_EN
    if (sum < 0) sum = 0;
`endif
    e.data = sum & 32'hFFFF;
    e.ch   = ch;
    e.last = (ch == 15) ? 1 : 0;
    return e;
  endfunction

  exp_t        q[$];
  logic [15:0] mb [16];
  int          mcnt = 0;
  int          n_out = 0;
  int          n_last = 0;
  logic        held = 1'b0;
  logic [15:0] h_data;
  logic [3:0]  h_ch;
  logic        h_sat, h_last;

  // Scoreboard: check outputs first, then update the model with this cycle's inputs.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 16; i++) mb[i] = 16'h0000;
      mcnt = 0;
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(h_data));
        chk("hold_ch", int'(out_ch), int'(h_ch));
        chk("hold_meta", int'({out_last, sat_flag}), int'({h_last, h_sat}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data", int'(out_data), e.data);
          chk("sb_ch", int'(out_ch), e.ch);
          chk("sb_last", int'(out_last), e.last);
          chk("sb_sat", int'(sat_flag), e.sat);
        end
        n_out++;
        if (out_last) n_last++;
      end
      held   = out_valid && !out_ready;
      h_data = out_data;
      h_ch   = out_ch;
      h_sat  = sat_flag;
      h_last = out_last;
      if (in_valid && in_ready) begin
        q.push_back(model(in_acc, mb[mcnt], mcnt));
        mcnt = (mcnt + 1) % 16;
      end
      if (ch_clr) mcnt = 0;
      if (bias_we) mb[bias_waddr] = bias_wdata;
    end
  end

  function automatic logic [23:0] rand_acc();
    case ($urandom_range(0, 2))
      0:       return 24'($urandom_range(0, 80000)) - 24'd40000;
      1:       return 24'($urandom);
      default: return $urandom_range(0, 1) ? 24'($urandom_range(32000, 33500))
                                           : 24'd0 - 24'($urandom_range(32000, 33500));
    endcase
  endfunction

  task automatic wr_bias(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bias_we = 1'b1; bias_waddr = a; bias_wdata = d;
    @(posedge clk); #1;
    bias_we = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 ch_clr = 1'b1;
    @(posedge clk); #1 ch_clr = 1'b0;
  endtask

  // One isolated beat on an idle pipeline; returns the result seen two cycles after accept.
  task automatic beat(input logic [23:0] acc, input logic clr, input logic we,
                      input logic [15:0] wd, output int d, output int ch, output int sat,
                      output int lst);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_acc = acc; ch_clr = clr;
    bias_we = we; bias_waddr = 4'd0; bias_wdata = wd;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; ch_clr = 1'b0; bias_we = 1'b0;
    @(negedge clk) chk("lat_not_early", int'(out_valid), 0);
    @(negedge clk) chk("lat_two_cycles", int'(out_valid), 1);
    d = int'(out_data); ch = int'(out_ch); sat = int'(sat_flag); lst = int'(out_last);
    repeat (2) @(posedge clk);
  endtask

  task automatic stream(input int n);
    int got = 0;
    int cyc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_acc = rand_acc();
    while (got < n && cyc < n + 50) begin
      @(negedge clk);
      if (in_ready) got++;
      @(posedge clk); #1;
      in_acc = rand_acc();
      if (got == n) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", got, n);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int d, ch, sat, lst, acc_n, n, out0, last0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_meta", int'({out_last, sat_flag}), 0);

    // Negative bias on ch3.
    wr_bias(4'd3, 16'h80F0);
    for (int i = 0; i < 4; i++) beat(24'd100, 1'b0, 1'b0, 16'h0, d, ch, sat, lst);
    chk("b3_ch", ch, 3);
`ifdef BIAS_RELU_EN
    chk("b3_data", d, 16'h0000);
`else
    chk("b3_data", d, 16'hFF74);
`endif
    chk("b3_sat", sat, 0);
    chk("b3_last", lst, 0);

    // Positive and negative saturation.
    wr_bias(4'd13, 16'h0429);
    wr_bias(4'd5, 16'h8001);
    pulse_clr();
    stream(5);
    beat(24'hFF8000, 1'b0, 1'b0, 16'h0, d, ch, sat, lst);
    chk("neg_sat_ch", ch, 5);
`ifdef BIAS_RELU_EN
    chk("neg_sat_data", d, 16'h0000);
`else
    chk("neg_sat_data", d, 16'h8000);
`endif
    chk("neg_sat_flag", sat, 1);
    stream(7);
    beat(24'd32752, 1'b0, 1'b0, 16'h0, d, ch, sat, lst);
    chk("pos_sat_ch", ch, 13);
    chk("pos_sat_data", d, 16'h7FFF);
    chk("pos_sat_flag", sat, 1);

    // Backpressure: two beats fit, the third waits.
    out0 = n_out;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_acc = rand_acc();
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) acc_n++;
      @(posedge clk); #1 in_acc = rand_acc();
    end
    @(negedge clk);
    chk("bp_accepted", acc_n, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    while (acc_n < 3 && n < 20) begin
      @(negedge clk);
      if (in_ready) acc_n++;
      @(posedge clk); #1;
      if (acc_n == 3) in_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    chk("bp_outputs", n_out - out0, 3);
    chk("bp_queue_empty", q.size(), 0);

    // Full-rate wrap and out_last.
    pulse_clr();
    last0 = n_last;
    out0 = n_out;
    stream(17);
    chk("wrap_outputs", n_out - out0, 17);
    chk("wrap_last_count", n_last - last0, 1);

    // ch_clr together with an accept.
    pulse_clr();
    stream(5);
    beat(24'd1, 1'b1, 1'b0, 16'h0, d, ch, sat, lst);
    chk("clr_beat_ch", ch, 5);
    beat(24'd1, 1'b0, 1'b0, 16'h0, d, ch, sat, lst);
    chk("after_clr_ch", ch, 0);

    // Write-during-accept uses the old bias.
    pulse_clr();
    beat(24'd10, 1'b0, 1'b1, 16'h0064, d, ch, sat, lst);
    chk("wr_same_cycle", d, 10);
    pulse_clr();
    beat(24'd10, 1'b0, 1'b0, 16'h0, d, ch, sat, lst);
    chk("wr_next_beat", d, 110);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_acc     = rand_acc();
      out_ready  = ($urandom_range(0, 3) != 0);
      bias_we    = ($urandom_range(0, 7) == 0);
      bias_waddr = 4'($urandom);
      bias_wdata = 16'($urandom);
      ch_clr     = ($urandom_range(0, 31) == 0);
      if (i == 1500) begin
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0; bias_we = 1'b0; ch_clr = 1'b0; out_ready = 1'b1;
        beat(24'd5, 1'b0, 1'b0, 16'h0, d, ch, sat, lst);
        chk("midrst_bias_zero", d, 5);
        chk("midrst_ch_zero", ch, 0);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; bias_we = 1'b0; ch_clr = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    chk("final_idle", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
